// File: rtl/interval_queue_if.sv
// Handshake bundle between the interval detector (master) and interval_queue (slave).
// Stats signals exist only when QUEUE_STATS_EN is defined.
interface interval_queue_if #(
  parameter int unsigned SI_W  = 32,
  parameter int unsigned EI_W  = 32,
  parameter int unsigned ID_W  = 32,
  parameter int unsigned DEPTH = 256
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [SI_W-1:0] si_in;
  logic [EI_W-1:0] ei_in;
  logic [ID_W-1:0] id_in;
  logic            out_valid;
  logic            out_ready;
  logic [SI_W-1:0] si_out;
  logic [EI_W-1:0] ei_out;
  logic [ID_W-1:0] id_out;
  logic [AW:0]     count;
  logic            full;
  logic            empty;
  logic            almost_full;
  logic            overflow;
`ifdef QUEUE_STATS_EN
  logic [AW:0]     peak_count;
  logic [15:0]     drop_count;

  modport master (
    output flush, in_valid, si_in, ei_in, id_in, out_ready,
    input  in_ready, out_valid, si_out, ei_out, id_out, count, full, empty, almost_full,
           overflow, peak_count, drop_count
  );
  modport slave (
    input  flush, in_valid, si_in, ei_in, id_in, out_ready,
    output in_ready, out_valid, si_out, ei_out, id_out, count, full, empty, almost_full,
           overflow, peak_count, drop_count
  );
`else
  modport master (
    output flush, in_valid, si_in, ei_in, id_in, out_ready,
    input  in_ready, out_valid, si_out, ei_out, id_out, count, full, empty, almost_full,
           overflow
  );
  modport slave (
    input  flush, in_valid, si_in, ei_in, id_in, out_ready,
    output in_ready, out_valid, si_out, ei_out, id_out, count, full, empty, almost_full,
           overflow
  );
`endif
endinterface

// File: rtl/interval_queue.sv
// Show-ahead FIFO of {si, ei, id} interval records with occupancy, almost-full, flush and
// sticky overflow. Define QUEUE_STATS_EN to add peak_count / drop_count statistics.
module interval_queue #(
  parameter int unsigned SI_W      = 32,
  parameter int unsigned EI_W      = 32,
  parameter int unsigned ID_W      = 32,
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AF_THRESH = 224
) (
  input logic          Clk,
  input logic          Rst,
  interval_queue_if.slave q
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned RW = SI_W + EI_W + ID_W;
  localparam logic [AW:0] AfLevel = (AW + 1)'(AF_THRESH);

  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          overflow_q;
  logic [RW-1:0] mem [DEPTH];

  logic [AW:0]   count;
  logic          full, empty, push, pop;

  always_comb begin
    count = wr_ptr_q - rd_ptr_q;
    full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    empty = (wr_ptr_q == rd_ptr_q);
    push  = q.in_valid & ~full;
    pop   = q.out_ready & ~empty;
  end

  assign q.in_ready    = ~full;
  assign q.out_valid   = ~empty;
  assign q.count       = count;
  assign q.full        = full;
  assign q.empty       = empty;
  assign q.almost_full = (count >= AfLevel);
  assign q.overflow    = overflow_q;
  assign {q.si_out, q.ei_out, q.id_out} = mem[rd_ptr_q[AW-1:0]];

  // Storage has no reset; writes are suppressed by flush/Rst so contents stay untouched.
  always_ff @(posedge Clk) begin
    if (push && !q.flush && !Rst) begin
      mem[wr_ptr_q[AW-1:0]] <= {q.si_in, q.ei_in, q.id_in};
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst || q.flush) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (q.in_valid && full) begin
        overflow_q <= 1'b1;
      end
    end
  end

`ifdef QUEUE_STATS_EN
  logic [AW:0] peak_q;
  logic [15:0] drop_q;

  // Stats survive flush; only Rst clears them.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      peak_q <= '0;
      drop_q <= '0;
    end else begin
      if (count > peak_q) begin
        peak_q <= count;
      end
      if (q.in_valid && full && !q.flush && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  assign q.peak_count = peak_q;
  assign q.drop_count = drop_q;
`endif
endmodule

// File: tb/tb_interval_queue.sv
// Randomized self-checking bench for interval_queue (DEPTH=8, AF_THRESH=6) against a
// queue-based reference model.
module tb_interval_queue;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AF    = 6;

  logic Clk = 1'b0;
  logic Rst = 1'b1;
  always #5 Clk = ~Clk;

  interval_queue_if #(.SI_W(32), .EI_W(32), .ID_W(32), .DEPTH(DEPTH)) q ();

  interval_queue #(
    .SI_W(32), .EI_W(32), .ID_W(32), .DEPTH(DEPTH), .AF_THRESH(AF)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .q(q)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Reference model
  logic [95:0] m_q[$];
  bit          m_ovf = 1'b0;
  int          m_peak = 0;
  int          m_drop = 0;

  function automatic logic [9:0] exp_status();
    int n;
    n = m_q.size();
    return {n < DEPTH, n > 0, n == DEPTH, n == 0, n >= AF, m_ovf, 4'(n)};
  endfunction

  function automatic logic [9:0] obs_status();
    return {q.in_ready, q.out_valid, q.full, q.empty, q.almost_full, q.overflow, q.count};
  endfunction

  function automatic logic [95:0] obs_head();
    return {q.si_out, q.ei_out, q.id_out};
  endfunction

  function automatic logic [95:0] rnd_rec();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_step(input bit rst, input bit fl, input bit iv, input bit orr,
                            input logic [95:0] rec);
    int n;
    n = m_q.size();
    if (rst) begin
      m_q.delete();
      m_ovf  = 1'b0;
      m_peak = 0;
      m_drop = 0;
    end else begin
      if (n > m_peak) m_peak = n;
      if (fl) begin
        m_q.delete();
        m_ovf = 1'b0;
      end else begin
        if (iv && n == DEPTH) begin
          m_ovf = 1'b1;
          if (m_drop < 65535) m_drop++;
        end
        if (orr && n > 0) void'(m_q.pop_front());
        if (iv && n < DEPTH) m_q.push_back(rec);
      end
    end
  endtask

  task automatic step(input bit rst, input bit fl, input bit iv, input bit orr,
                      input logic [95:0] rec);
    Rst        = rst;
    q.flush    = fl;
    q.in_valid = iv;
    q.out_ready = orr;
    {q.si_in, q.ei_in, q.id_in} = rec;
    model_step(rst, fl, iv, orr, rec);
    @(posedge Clk);
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0, '0);
    step(1, 0, 1, 1, rnd_rec());
    step(0, 0, 0, 0, '0);
    n_cmp++;
    if (obs_status() !== 10'b1_0_0_1_0_0_0000) begin
      n_err++;
      $display("FAIL reset_status got=%b exp=%b", obs_status(), 10'b1001000000);
    end
  endtask

  task automatic test_order();
    for (int i = 1; i <= 3; i++) step(0, 0, 1, 0, {32'(i), $urandom(), $urandom()});
    step(0, 0, 0, 0, '0);
    n_cmp++;
    if (obs_status() !== exp_status() || q.count !== 4'd3) begin
      n_err++;
      $display("FAIL order_count got=%b exp=%b", obs_status(), exp_status());
    end
    for (int i = 1; i <= 3; i++) begin
      n_cmp++;
      if (q.si_out !== 32'(i) || obs_head() !== m_q[0]) begin
        n_err++;
        $display("FAIL order_head%0d got=%h exp_si=%0d", i, obs_head(), i);
      end
      step(0, 0, 0, 1, '0);
    end
    n_cmp++;
    if (q.empty !== 1'b1 || obs_status() !== exp_status()) begin
      n_err++;
      $display("FAIL order_empty got=%b exp=%b", obs_status(), exp_status());
    end
  endtask

  task automatic test_full();
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 0, 1, 0, rnd_rec());
      n_cmp++;
      if (obs_status() !== exp_status() || q.almost_full !== (i + 1 >= AF)) begin
        n_err++;
        $display("FAIL fill_%0d got=%b exp=%b", i + 1, obs_status(), exp_status());
      end
    end
    step(0, 0, 1, 0, rnd_rec());
    n_cmp++;
    if (obs_status() !== exp_status() || q.overflow !== 1'b1 || q.in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL overflow got=%b exp=%b", obs_status(), exp_status());
    end
    while (m_q.size() > 0) begin
      n_cmp++;
      if (obs_head() !== m_q[0]) begin
        n_err++;
        $display("FAIL full_drain got=%h exp=%h", obs_head(), m_q[0]);
      end
      step(0, 0, 0, 1, '0);
    end
  endtask

  task automatic test_full_pushpop();
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, rnd_rec());
    step(0, 0, 1, 1, rnd_rec());
    n_cmp++;
    if (obs_status() !== exp_status() || q.count !== 4'd7) begin
      n_err++;
      $display("FAIL full_pushpop got=%b exp=%b", obs_status(), exp_status());
    end
    step(0, 0, 1, 1, rnd_rec());
    n_cmp++;
    if (obs_status() !== exp_status() || q.count !== 4'd7) begin
      n_err++;
      $display("FAIL held_pushpop got=%b exp=%b", obs_status(), exp_status());
    end
    while (m_q.size() > 0) begin
      n_cmp++;
      if (obs_head() !== m_q[0]) begin
        n_err++;
        $display("FAIL pp_drain got=%h exp=%h", obs_head(), m_q[0]);
      end
      step(0, 0, 0, 1, '0);
    end
  endtask

  task automatic test_random_wrap();
    int errs;
    errs = 0;
    step(1, 0, 0, 0, '0);
    for (int c = 0; c < 150; c++) begin
      step(0, 0, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, rnd_rec());
      n_cmp++;
      if (obs_status() !== exp_status() || (m_q.size() > 0 && obs_head() !== m_q[0])) begin
        n_err++;
        errs++;
        if (errs < 10)
          $display("FAIL random cyc=%0d got=%b/%h exp=%b", c, obs_status(), obs_head(),
                   exp_status());
      end
`ifdef QUEUE_STATS_EN
      n_cmp++;
      if (q.peak_count !== 4'(m_peak) || q.drop_count !== 16'(m_drop)) begin
        n_err++;
        $display("FAIL random_stats cyc=%0d got=%0d/%0d exp=%0d/%0d", c, q.peak_count,
                 q.drop_count, m_peak, m_drop);
      end
`endif
    end
  endtask

  task automatic test_flush();
    logic [95:0] r;
    step(1, 0, 0, 0, '0);
    for (int i = 0; i <= DEPTH; i++) step(0, 0, 1, 0, rnd_rec());
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, '0);
    n_cmp++;
    if (obs_status() !== exp_status() || q.count !== 4'd5 || q.overflow !== 1'b1) begin
      n_err++;
      $display("FAIL pre_flush got=%b exp=%b", obs_status(), exp_status());
    end
    step(0, 1, 1, 1, rnd_rec());
    n_cmp++;
    if (obs_status() !== 10'b1_0_0_1_0_0_0000) begin
      n_err++;
      $display("FAIL flush got=%b exp=%b", obs_status(), 10'b1001000000);
    end
    r = rnd_rec();
    step(0, 0, 1, 0, r);
    n_cmp++;
    if (obs_head() !== r || obs_status() !== exp_status()) begin
      n_err++;
      $display("FAIL post_flush got=%h exp=%h", obs_head(), r);
    end
  endtask

`ifdef QUEUE_STATS_EN
  task automatic test_stats();
    step(1, 0, 0, 0, '0);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0, rnd_rec());
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, rnd_rec());
    step(0, 1, 0, 0, '0);
    step(0, 0, 0, 0, '0);
    n_cmp++;
    if (q.peak_count !== 4'd8 || q.drop_count !== 16'd3 || m_peak != 8 || m_drop != 3) begin
      n_err++;
      $display("FAIL stats got=%0d/%0d exp=8/3", q.peak_count, q.drop_count);
    end
    n_cmp++;
    if (q.empty !== 1'b1 || q.overflow !== 1'b0) begin
      n_err++;
      $display("FAIL stats_flush got=%b exp=empty,no-ovf", obs_status());
    end
  endtask
`endif

  initial begin
    q.flush = 1'b0;
    q.in_valid = 1'b0;
    q.out_ready = 1'b0;
    q.si_in = '0;
    q.ei_in = '0;
    q.id_in = '0;
    test_reset();
    test_order();
    test_full();
    test_full_pushpop();
    test_random_wrap();
    test_flush();
`ifdef QUEUE_STATS_EN
    test_stats();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
